// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Groups the byte-buffer handshake between the UART receiver / command
// interface (master) and the receive FIFO (slave).
//   i_data     : received byte, meaningful while i_valid is high
//   i_valid    : single-cycle write strobe from the receiver
//   i_pop      : consumer acknowledges the head byte
//   i_clr_ovf  : clears the sticky overflow flag
//   o_data     : head byte (fall-through), 0 when empty
//   o_valid    : at least one byte stored
//   o_empty    : no bytes stored
//   o_full     : DEPTH bytes stored
//   o_count    : occupancy 0..DEPTH
//   o_overflow : sticky, a write was dropped while full
interface uart_rx_fifo_if #(
    parameter int N     = 8,
    parameter int DEPTH = 16
);
    logic [N-1:0]             i_data;
    logic                     i_valid;
    logic                     i_pop;
    logic                     i_clr_ovf;
    logic [N-1:0]             o_data;
    logic                     o_valid;
    logic                     o_empty;
    logic                     o_full;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     o_overflow;

    modport master (
        output i_data, i_valid, i_pop, i_clr_ovf,
        input  o_data, o_valid, o_empty, o_full, o_count, o_overflow
    );

    modport slave (
        input  i_data, i_valid, i_pop, i_clr_ovf,
        output o_data, o_valid, o_empty, o_full, o_count, o_overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer between the UART receiver and the command
// interface. Captures every strobed byte, presents bytes in arrival order
// through a first-word-fall-through pop handshake and flags bytes dropped
// because the buffer was full.
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : asynchronous active-low reset, clears pointers and overflow
//   bus   : uart_rx_fifo_if slave modport (write strobe, pop, status, head)
module uart_rx_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_rx_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         overflow;
    logic         empty;
    logic         full;
    logic         do_push;
    logic         do_pop;
    logic         drop;

    // Pointers carry one extra bit so that equal low bits can mean either
    // empty (same lap) or full (writer one lap ahead).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A write while full is still accepted when the head is popped in the
    // same cycle, because that pop frees the slot being written.
    assign do_pop  = bus.i_pop && !empty;
    assign do_push = bus.i_valid && (!full || bus.i_pop);
    assign drop    = bus.i_valid && full && !bus.i_pop;

    // Storage has no reset: stale entries are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= bus.i_data;
        end
    end

    // Pointer and overflow state; a new drop takes priority over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.i_clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.o_data     = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.o_valid    = !empty;
    assign bus.o_empty    = empty;
    assign bus.o_full     = full;
    assign bus.o_count    = wr_ptr - rd_ptr;
    assign bus.o_overflow = overflow;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the command interface. It captures every byte that the receiver strobes out, even while the interface is still busy with a previous operand. It then presents the bytes in arrival order through a pop handshake. This decouples ALU command assembly from serial arrival timing and flags bytes lost to overflow.

## Interface

- N, 8, data width in bits (one UART word)
- DEPTH, 16, number of entries; power of two, minimum 2
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; clears all state immediately
- i_data  input  N  received byte, valid only while i_valid is high
- i_valid  input  1  single-cycle write strobe from the receiver (its `valid`)
- i_pop  input  1  consumer acknowledges the head byte; ignored when empty
- i_clr_ovf  input  1  clears the sticky overflow flag
- o_data  output  N  head byte (first-word-fall-through); 0 when empty
- o_valid  output  1  high when at least one byte is stored (equal to !o_empty)
- o_empty  output  1  FIFO holds 0 entries
- o_full  output  1  FIFO holds DEPTH entries
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- o_overflow  output  1  sticky; set when a write is dropped

## Operation

- Storage is a DEPTH x N register array.
  - Write pointer and read pointer are each $clog2(DEPTH)+1 bits.
  - Only the low bits index the array.
  - The MSB distinguishes full from empty.
- Empty when the pointers are equal.
- Full when the low bits are equal and the MSBs differ.
- o_count is wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Push: i_valid high and (not full, or full with i_pop high in the same cycle). The write goes to mem[wr_ptr], then wr_ptr increments.
- Pop: i_pop high and not empty; rd_ptr increments.
- Both pointers wrap naturally at 2^($clog2(DEPTH)+1); no special case at the array boundary.
- Simultaneous push and pop:
  - Non-empty: both happen; count unchanged.
  - Full: both happen; the popped slot is reused and count stays DEPTH.
  - Empty: push only (nothing to pop); count becomes 1.
- Overflow: i_valid high, full, and i_pop low.
  - The byte is dropped and memory and pointers are unchanged.
  - o_overflow is set.
- o_overflow stays set until i_clr_ovf is sampled high. If a new overflow coincides with i_clr_ovf, set wins.
- Pop on empty: no effect, no error flag.
- Reset (asserted at any time, including mid-burst):
  - Pointers, count and o_overflow go to 0.
  - o_empty = 1, o_full = 0, o_valid = 0, o_data = 0.
  - Array contents are not cleared and are unreachable after reset.
- No state machine. Behaviour is fully defined by the two pointers plus the overflow register.

## Timing

- Push latency: a byte strobed at edge k appears on o_data (if the FIFO was empty), and o_valid/o_count update, immediately after edge k. One-cycle write-to-read latency.
- o_data is combinational from mem[rd_ptr], gated to 0 when empty. No extra read cycle.
- Pop takes effect at the sampling edge. The next byte, or 0 if now empty, is on o_data after that edge.
  - The consumer must drop i_pop in the cycle after a pop unless it intends to consume the next byte too.
- Back-to-back pops on consecutive cycles are legal and drain one byte per cycle.
- o_full, o_empty, o_count and o_overflow are all derived from registered state. They are stable for the whole cycle after each edge.
- Reset deassertion is assumed synchronised externally. The first push is accepted on the first rising edge with reset high.

## Test plan

- Reset, then push 0x11, 0x22, 0x33 on separate cycles, then pop 3 times.
  - Pops return 0x11, 0x22, 0x33 in order.
  - o_count reads 3→2→1→0.
  - o_empty returns to 1; o_data returns to 0.
- Fill with 16 bytes 0x00..0x0F, then push 0xAA with i_pop low.
  - o_full = 1, o_overflow = 1.
  - Draining yields exactly 0x00..0x0F; 0xAA never appears.
- Fill to full, then drive push 0x55 and pop in the same cycle.
  - o_count stays 16 and o_overflow stays 0.
  - The head advances to 0x01, and 0x55 is the last byte drained.
- Empty FIFO, push 0x7E with i_pop high in the same cycle.
  - Count becomes 1 and o_data = 0x7E.
  - A pop on empty with no push leaves count 0 and raises no flags.
- Run 40 push/pop cycles at a steady occupancy of 5 with incrementing data.
  - Pointers wrap at least twice.
  - Every byte is returned in order with no loss.
- Assert reset (low) mid-fill at count 7, with o_overflow previously set.
  - Outputs go immediately to count 0, empty 1, full 0, overflow 0, data 0.
  - A subsequent push of 0x3C is read back as the head.
  - i_clr_ovf coincident with an overflow leaves o_overflow = 1.
